// File: rtl/cpu_out_uart.sv
// OUT-port logger: FIFO of strobed bytes, formatted as decimal text + CR LF, sent 8N1 on tx_o.
// Define OUT_UART_HEX_EN to emit two uppercase hex digits + CR LF instead of decimal.
module cpu_out_uart #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic       out_strobe_i,
    input  logic [7:0] out_value_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       overflow_o
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
`ifdef OUT_UART_HEX_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 5;
`endif
    localparam int IW = $clog2(NCH);

    typedef enum logic [1:0] {F_IDLE, F_POP, F_CONV, F_EMIT} fstate_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tstate_t;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                empty, full, push;
    fstate_t             fstate;
    logic [7:0]          val;
    logic [NCH-1:0][7:0] chars;
    logic [IW-1:0]       cidx;
`ifndef OUT_UART_HEX_EN
    logic [1:0]          hund;
    logic [3:0]          tens;
`endif
    tstate_t             tstate;
    logic [CW-1:0]       bcnt;
    logic [2:0]          bidx;
    logic [7:0]          sh;
    logic                bit_end, tx_ready, tx_accept;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push      = out_strobe_i && !full;
    assign bit_end   = (bcnt == CW'(DIV - 1));
    assign tx_ready  = (tstate == T_IDLE) || ((tstate == T_STOP) && bit_end);
    assign tx_accept = (fstate == F_EMIT) && tx_ready;

`ifdef OUT_UART_HEX_EN
    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction
`endif

    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= out_value_i;

    // A strobe that meets a full FIFO is lost even if a pop happens on the same edge.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr     <= '0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (out_strobe_i && full) overflow_o <= 1'b1;
            busy_o <= push || !empty || (fstate != F_IDLE) || (tstate != T_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fstate <= F_IDLE;
            rd_ptr <= '0;
            val    <= '0;
            chars  <= '0;
            cidx   <= '0;
`ifndef OUT_UART_HEX_EN
            hund   <= '0;
            tens   <= '0;
`endif
        end else begin
            case (fstate)
                F_IDLE: if (!empty) fstate <= F_POP;
                F_POP: begin
                    val    <= mem[rd_ptr[AW-1:0]];
                    rd_ptr <= rd_ptr + 1'b1;
                    cidx   <= '0;
`ifndef OUT_UART_HEX_EN
                    hund   <= '0;
                    tens   <= '0;
`endif
                    fstate <= F_CONV;
                end
                F_CONV: begin
`ifdef OUT_UART_HEX_EN
                    chars[0] <= hexc(val[7:4]);
                    chars[1] <= hexc(val[3:0]);
                    chars[2] <= 8'h0D;
                    chars[3] <= 8'h0A;
                    fstate   <= F_EMIT;
`else
                    // Repeated subtraction; whatever is left below 10 is the units digit.
                    if (val >= 8'd100) begin
                        val  <= val - 8'd100;
                        hund <= hund + 1'b1;
                    end else if (val >= 8'd10) begin
                        val  <= val - 8'd10;
                        tens <= tens + 1'b1;
                    end else begin
                        chars[0] <= (hund == 2'd0) ? 8'h20 : 8'h30 + {6'd0, hund};
                        chars[1] <= (hund == 2'd0 && tens == 4'd0) ? 8'h20 : 8'h30 + {4'd0, tens};
                        chars[2] <= 8'h30 + val;
                        chars[3] <= 8'h0D;
                        chars[4] <= 8'h0A;
                        fstate   <= F_EMIT;
                    end
`endif
                end
                F_EMIT: if (tx_ready) begin
                    if (cidx == IW'(NCH - 1)) fstate <= F_IDLE;
                    else                      cidx   <= cidx + 1'b1;
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end

    // The next character is loaded on the last clock of STOP so frames run back-to-back.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tstate <= T_IDLE;
            bcnt   <= '0;
            bidx   <= '0;
            sh     <= '0;
            tx_o   <= 1'b1;
        end else begin
            case (tstate)
                T_IDLE: begin
                    tx_o <= 1'b1;
                    if (tx_accept) begin
                        sh     <= chars[cidx];
                        bcnt   <= '0;
                        tstate <= T_START;
                        tx_o   <= 1'b0;
                    end
                end
                T_START: begin
                    if (bit_end) begin
                        bcnt   <= '0;
                        bidx   <= '0;
                        tstate <= T_DATA;
                        tx_o   <= sh[0];
                    end else bcnt <= bcnt + 1'b1;
                end
                T_DATA: begin
                    if (bit_end) begin
                        bcnt <= '0;
                        if (bidx == 3'd7) begin
                            tstate <= T_STOP;
                            tx_o   <= 1'b1;
                        end else begin
                            bidx <= bidx + 1'b1;
                            tx_o <= sh[bidx + 3'd1];
                        end
                    end else bcnt <= bcnt + 1'b1;
                end
                T_STOP: begin
                    if (bit_end) begin
                        bcnt <= '0;
                        if (tx_accept) begin
                            sh     <= chars[cidx];
                            tstate <= T_START;
                            tx_o   <= 1'b0;
                        end else tstate <= T_IDLE;
                    end else bcnt <= bcnt + 1'b1;
                end
                default: tstate <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_out_uart.sv
// Randomized bench for cpu_out_uart: a mid-bit sampling UART receiver feeds a queue that is
// compared against text formatted directly from the strobed values.
module tb_cpu_out_uart;
    // A faster baud keeps the run short; the bit period still follows the rounding rule.
    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 230400;
    localparam int DEPTH  = 8;
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int FRAME  = 10 * DIV;
`ifdef OUT_UART_HEX_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 5;
`endif
    localparam int IDLE_LIM = 60 * FRAME;

    logic       clk = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       out_strobe_i = 1'b0;
    logic [7:0] out_value_i = '0;
    logic       tx_o, busy_o, overflow_o;

    cpu_out_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n_i(reset_n_i), .out_strobe_i(out_strobe_i),
        .out_value_i(out_value_i), .tx_o(tx_o), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver: start on a falling edge, sample each bit mid-period, and flag any edge of
    // tx_o that is not on a bit boundary.
    logic       tx_prev = 1'b1;
    logic       rx_on = 1'b0;
    int         rx_cnt = 0;
    int         rx_err = 0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rx_q[$];
    int         st_q[$];

    always @(negedge clk) begin
        if (!reset_n_i) begin
            rx_on   <= 1'b0;
            tx_prev <= 1'b1;
        end else begin
            tx_prev <= tx_o;
            if (!rx_on) begin
                if (tx_prev === 1'b1 && tx_o === 1'b0) begin
                    rx_on  <= 1'b1;
                    rx_cnt <= 1;
                    st_q.push_back(cyc);
                end
            end else begin
                rx_cnt <= rx_cnt + 1;
                if (tx_o !== tx_prev && (rx_cnt % DIV) != 0) rx_err <= rx_err + 1;
                if (rx_cnt == DIV / 2 && tx_o !== 1'b0) rx_err <= rx_err + 1;
                if (rx_cnt > DIV && rx_cnt < 9 * DIV && (rx_cnt % DIV) == DIV / 2)
                    rx_sh <= {tx_o, rx_sh[7:1]};
                if (rx_cnt == 9 * DIV + DIV / 2) begin
                    if (tx_o !== 1'b1) rx_err <= rx_err + 1;
                    rx_q.push_back(rx_sh);
                    rx_on <= 1'b0;
                end
            end
        end
    end

    // Reference text for one value.
    logic [7:0] exp_q[$];
    function automatic logic [7:0] hexch(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction
    function automatic void model(input int v);
`ifdef OUT_UART_HEX_EN
        exp_q.push_back(hexch(v / 16));
        exp_q.push_back(hexch(v % 16));
`else
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        exp_q.push_back(h != 0 ? 8'(48 + h) : 8'h20);
        exp_q.push_back((h != 0 || t != 0) ? 8'(48 + t) : 8'h20);
        exp_q.push_back(8'(48 + u));
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic strobe(input logic [7:0] v);
        @(negedge clk);
        out_strobe_i = 1'b1;
        out_value_i  = v;
        @(negedge clk);
        out_strobe_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o === 1'b1 && n < IDLE_LIM) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy_o, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag);
        int gaps = 0;
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_ch%0d", tag, i), rx_q[i], exp_q[i]);
        for (int i = 1; i < st_q.size(); i++)
            if (st_q[i] - st_q[i-1] != FRAME) gaps++;
        check({tag, "_b2b"}, gaps, 0);
        check({tag, "_framing"}, rx_err, 0);
        rx_q.delete();
        exp_q.delete();
        st_q.delete();
    endtask

    initial begin
        int c0, st0, bf, n, bad;
        logic [7:0] v;

        repeat (3) @(negedge clk);
        check("rst_tx", tx_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        reset_n_i = 1'b1;

        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || overflow_o !== 1'b0) bad++;
        end
        check("quiet_2000", bad, 0);

        // Single value: first start bit within 16 clocks, busy for exactly NCH frames.
        @(negedge clk);
        c0 = cyc;
        out_strobe_i = 1'b1;
        out_value_i  = 8'd42;
        @(negedge clk);
        out_strobe_i = 1'b0;
        model(42);
        check("t2_busy_up", busy_o, 1'b1);
        n = 0;
        while (st_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t2_start_seen", st_q.size() > 0, 1'b1);
        st0 = (st_q.size() > 0) ? st_q[0] : 0;
        check("t2_latency_le16", (st0 - (c0 + 1)) >= 1 && (st0 - (c0 + 1)) <= 16, 1'b1);
        n = 0;
        while (busy_o === 1'b1 && n < IDLE_LIM) begin
            @(negedge clk);
            n++;
        end
        bf = cyc;
        check("t2_busy_fall", (bf - st0) >= NCH * FRAME && (bf - st0) <= NCH * FRAME + 2, 1'b1);
        repeat (4) @(negedge clk);
        compare_stream("t2");

        foreach (exp_q[i]) exp_q.delete(); // nothing pending
        strobe(8'd0);   model(0);
        strobe(8'd9);   model(9);
        strobe(8'd100); model(100);
        strobe(8'd255); model(255);
        wait_idle("t3");
        check("t3_ovf", overflow_o, 1'b0);
        compare_stream("t3");

        repeat (4) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                v = 8'($urandom_range(0, 255));
                strobe(v);
                model(int'(v));
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
            wait_idle("rnd");
            compare_stream("rnd");
        end
        check("rnd_ovf", overflow_o, 1'b0);

        // Burst of 12: one value is already in the formatter when the FIFO fills,
        // so DEPTH+1 values get through and the rest are dropped.
        @(negedge clk);
        for (int i = 1; i <= 12; i++) begin
            out_strobe_i = 1'b1;
            out_value_i  = 8'(i);
            @(negedge clk);
        end
        out_strobe_i = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) model(i);
        check("t4_ovf_set", overflow_o, 1'b1);
        wait_idle("t4");
        check("t4_ovf_sticky", overflow_o, 1'b1);
        compare_stream("t4");

        // Reset in the middle of data bit 2 of the second character of 123.
        strobe(8'd123);
        n = 0;
        while (st_q.size() < 2 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("t5_second_start", st_q.size(), 2);
        repeat (3 * DIV + DIV / 2) @(negedge clk);
        check("t5_pre_rst_tx", tx_o, 1'b0);
        reset_n_i = 1'b0;
        #1;
        check("t5_async_tx", tx_o, 1'b1);
        check("t5_rst_busy", busy_o, 1'b0);
        check("t5_rst_ovf", overflow_o, 1'b0);
        repeat (3) @(negedge clk);
        reset_n_i = 1'b1;
        rx_q.delete();
        st_q.delete();
        exp_q.delete();
        strobe(8'd5);
        model(5);
        wait_idle("t5");
        compare_stream("t5");

        strobe(8'h0A); model(8'h0A);
        strobe(8'hFF); model(8'hFF);
        wait_idle("t6");
        compare_stream("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
